// File: rtl/pit_arbiter_pkg.sv
// Shared types and limits for the minipit scheduler.
// Pure declarations: no logic, no latency, no flow control.
package pit_arbiter_pkg;
    localparam int COUNT_W     = 16;
    localparam int WDOG_W      = 20;
    localparam int NUM_REQ_MAX = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_WAIT,
        S_DONE
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first pending channel strictly after last_grant, wrapping.
// Combinational, zero latency; no backpressure (pure function of its inputs).
module rr_arbiter
    import pit_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    // Scan from the farthest offset down so the nearest pending channel wins last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (pending[IDX_W'((int'(last_grant) + off) % NUM_REQ)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/pit_arbiter.sv
// Shares one minipit among NUM_REQ one-shot timeout clients; optional PIT_ARBITER_WATCHDOG_EN aborts long waits.
// Latency: accept -> pit_write_en 2 cycles, pit_irq -> done 1 cycle, zero count -> done 2 cycles.
// Backpressure: req_ready[i] low while channel i is pending; req_valid then is dropped.
module pit_arbiter
    import pit_arbiter_pkg::*;
#(
    parameter int                NUM_REQ     = 4,
    parameter logic [WDOG_W-1:0] WDOG_CYCLES = 20'hFFFFF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*COUNT_W-1:0]   req_count,
    input  logic [NUM_REQ-1:0]           req_div,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           done,
    output logic [NUM_REQ-1:0]           timeout,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         pit_write_en,
    output logic [7:0]                   pit_counter_high,
    output logic [7:0]                   pit_counter_low,
    output logic                         pit_divider_on,
    output logic                         pit_repeating,
    input  logic                         pit_irq
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX || WDOG_CYCLES == '0) begin : g_bad_cfg
        $error("pit_arbiter: unsupported NUM_REQ or WDOG_CYCLES");
    end

    state_t               state;
    logic [NUM_REQ-1:0]   pending;
    logic [COUNT_W-1:0]   cnt_q [NUM_REQ];
    logic [NUM_REQ-1:0]   div_q;
    logic [IDX_W-1:0]     last_grant;
    logic                 grant_valid;
    logic [IDX_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]   accept;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [NUM_REQ-1:0]   clr_mask;

    assign req_ready     = ~pending;
    assign accept        = req_valid & ~pending;
    assign grant_oh      = NUM_REQ'(1) << grant_id;
    assign pick_oh       = NUM_REQ'(1) << grant_idx;
    assign clr_mask      = (state == S_DONE) ? grant_oh : '0;
    assign pit_repeating = 1'b1;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .pending     (pending),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // The granted channel cannot re-accept until its pending bit drops at the end of DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            div_q   <= '0;
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    cnt_q[i] <= req_count[i*COUNT_W +: COUNT_W];
                    div_q[i] <= req_div[i];
                end
            end
            pending <= (pending | accept) & ~clr_mask;
        end
    end

`ifdef PIT_ARBITER_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;
`else
    assign timeout = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            last_grant       <= IDX_W'(NUM_REQ - 1);
            grant_id         <= '0;
            busy             <= 1'b0;
            done             <= '0;
            pit_write_en     <= 1'b0;
            pit_counter_high <= '0;
            pit_counter_low  <= '0;
            pit_divider_on   <= 1'b0;
`ifdef PIT_ARBITER_WATCHDOG_EN
            timeout          <= '0;
            wdog_cnt         <= '0;
`endif
        end else begin
            pit_write_en <= 1'b0;
            done         <= '0;
`ifdef PIT_ARBITER_WATCHDOG_EN
            timeout      <= '0;
`endif
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        grant_id   <= grant_idx;
                        last_grant <= grant_idx;
                        busy       <= 1'b1;
                        if (cnt_q[grant_idx] == '0) begin
                            state <= S_DONE;
                            done  <= pick_oh;
                        end else begin
                            state            <= S_LOAD;
                            pit_write_en     <= 1'b1;
                            pit_counter_high <= cnt_q[grant_idx][15:8];
                            pit_counter_low  <= cnt_q[grant_idx][7:0];
                            pit_divider_on   <= div_q[grant_idx];
                        end
                    end
                end
                S_LOAD: state <= S_ARM;
                // An interrupt seen here belongs to the previous programming.
                S_ARM: begin
                    state <= S_WAIT;
`ifdef PIT_ARBITER_WATCHDOG_EN
                    wdog_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (pit_irq) begin
                        state <= S_DONE;
                        done  <= grant_oh;
                    end
`ifdef PIT_ARBITER_WATCHDOG_EN
                    else if (wdog_cnt == WDOG_CYCLES - 1'b1) begin
                        state   <= S_DONE;
                        timeout <= grant_oh;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pit_arbiter.sv
// Directed bench for pit_arbiter with NUM_REQ=4 and WDOG_CYCLES=20.
module tb_pit_arbiter;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N*16-1:0] req_count;
    logic [N-1:0]  req_div;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  done;
    logic [N-1:0]  timeout;
    logic          busy;
    logic [1:0]    grant_id;
    logic          pit_write_en;
    logic [7:0]    pit_counter_high;
    logic [7:0]    pit_counter_low;
    logic          pit_divider_on;
    logic          pit_repeating;
    logic          pit_irq;

    int n_chk = 0;
    int n_bad = 0;

    pit_arbiter #(.NUM_REQ(N), .WDOG_CYCLES(20'd20)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_count        (req_count),
        .req_div          (req_div),
        .req_ready        (req_ready),
        .done             (done),
        .timeout          (timeout),
        .busy             (busy),
        .grant_id         (grant_id),
        .pit_write_en     (pit_write_en),
        .pit_counter_high (pit_counter_high),
        .pit_counter_low  (pit_counter_low),
        .pit_divider_on   (pit_divider_on),
        .pit_repeating    (pit_repeating),
        .pit_irq          (pit_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge; inputs change and outputs are sampled there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int ch, input logic [15:0] cnt, input logic dv);
        req_valid[ch]          = 1'b1;
        req_count[ch*16 +: 16] = cnt;
        req_div[ch]            = dv;
    endtask

    // Wait (bounded) for LOAD, check the programming, then complete via pit_irq.
    task automatic serve(input int exp_id, input logic [15:0] exp_cnt, input int exp_gap);
        int n = 0;
        while (!pit_write_en && n < 20) begin
            step();
            n++;
        end
        chk("load_seen", 32'(pit_write_en), 1);
        if (exp_gap >= 0) chk("idle_gap", n, exp_gap);
        chk("grant_id", 32'(grant_id), exp_id);
        chk("pit_count", {pit_counter_high, pit_counter_low}, 32'(exp_cnt));
        step();                              // ARM
        step();                              // WAIT
        pit_irq = 1'b1;
        step();                              // DONE
        pit_irq = 1'b0;
        chk("done_oh", 32'(done), 32'(1) << exp_id);
        chk("no_timeout", 32'(timeout), 0);
        step();                              // IDLE
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_count = '0;
        req_div   = '0;
        pit_irq   = 1'b0;
        step();
        step();
        chk("rst_busy",      32'(busy), 0);
        chk("rst_ready",     32'(req_ready), 32'hF);
        chk("rst_done",      32'(done), 0);
        chk("rst_we",        32'(pit_write_en), 0);
        chk("rst_grant",     32'(grant_id), 0);
        chk("rst_repeating", 32'(pit_repeating), 1);
        chk("rst_count",     {pit_counter_high, pit_counter_low}, 0);
        reset = 1'b0;
        step();

        // Single request, ch2, count 5, div 0.
        post(2, 16'h0005, 1'b0);
        step();
        req_valid = '0;
        chk("s_ready",  32'(req_ready), 32'hB);
        chk("s_we_c1",  32'(pit_write_en), 0);
        chk("s_busy_c1", 32'(busy), 0);
        step();
        chk("s_we_c2",  32'(pit_write_en), 1);
        chk("s_high",   32'(pit_counter_high), 0);
        chk("s_low",    32'(pit_counter_low), 5);
        chk("s_div",    32'(pit_divider_on), 0);
        chk("s_grant",  32'(grant_id), 2);
        chk("s_busy",   32'(busy), 1);
        step();
        chk("s_we_arm", 32'(pit_write_en), 0);
        chk("s_hold",   32'(pit_counter_low), 5);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s_wait_done", 32'(done), 0);
        end
        pit_irq = 1'b1;
        step();
        pit_irq = 1'b0;
        chk("s_done", 32'(done), 32'h4);
        step();
        chk("s_done_pulse", 32'(done), 0);
        chk("s_idle_busy",  32'(busy), 0);
        chk("s_ready_back", 32'(req_ready), 32'hF);

        // Stale interrupt during ARM, ch3 count 0x1234 with divider.
        post(3, 16'h1234, 1'b1);
        step();
        req_valid = '0;
        step();
        chk("st_high", 32'(pit_counter_high), 32'h12);
        chk("st_low",  32'(pit_counter_low), 32'h34);
        chk("st_div",  32'(pit_divider_on), 1);
        step();                              // ARM
        pit_irq = 1'b1;
        step();                              // WAIT
        pit_irq = 1'b0;
        chk("st_ignored", 32'(done), 0);
        for (int i = 0; i < 30; i++) step();
        chk("st_still_wait", 32'(busy), 1);
        chk("st_no_done",    32'(done), 0);
        pit_irq = 1'b1;
        step();
        pit_irq = 1'b0;
        chk("st_done", 32'(done), 32'h8);
        step();

        // Round-robin: ch0, ch1, ch3 together, then ch0 + ch3.
        post(0, 16'h0010, 1'b0);
        post(1, 16'h0011, 1'b0);
        post(3, 16'h0033, 1'b0);
        step();
        req_valid = '0;
        serve(0, 16'h0010, 1);
        serve(1, 16'h0011, 1);
        serve(3, 16'h0033, 1);
        post(0, 16'h00A0, 1'b0);
        post(3, 16'h00A3, 1'b0);
        step();
        req_valid = '0;
        serve(0, 16'h00A0, 1);
        serve(3, 16'h00A3, 1);

        // Zero count and dropped request while pending.
        post(1, 16'h0000, 1'b0);
        step();
        chk("z_ready", 32'(req_ready), 32'hD);
        post(1, 16'h0007, 1'b0);
        chk("z_we_c1", 32'(pit_write_en), 0);
        step();
        req_valid = '0;
        chk("z_done",  32'(done), 32'h2);
        chk("z_we_c2", 32'(pit_write_en), 0);
        step();
        chk("z_done_pulse", 32'(done), 0);
        chk("z_ready_back", 32'(req_ready), 32'hF);
        step();
        chk("z_no_retry", 32'(busy), 0);

        // Reset in the middle of WAIT.
        post(0, 16'h0009, 1'b0);
        step();
        req_valid = '0;
        step();
        step();
        step();
        chk("r_in_wait", 32'(busy), 1);
        reset = 1'b1;
        pit_irq = 1'b1;
        step();
        chk("r_busy",  32'(busy), 0);
        chk("r_ready", 32'(req_ready), 32'hF);
        chk("r_done",  32'(done), 0);
        reset   = 1'b0;
        pit_irq = 1'b0;
        step();
        chk("r_no_done", 32'(done), 0);
        post(2, 16'h0022, 1'b0);
        post(0, 16'h0020, 1'b0);
        step();
        req_valid = '0;
        serve(0, 16'h0020, 1);
        serve(2, 16'h0022, 1);

`ifdef PIT_ARBITER_WATCHDOG_EN
        post(1, 16'h0100, 1'b0);
        post(2, 16'h0200, 1'b0);
        step();
        req_valid = '0;
        step();
        chk("w_load", 32'(pit_write_en), 1);
        chk("w_grant", 32'(grant_id), 1);
        step();                              // ARM
        step();                              // WAIT cycle 0
        for (int i = 1; i < 20; i++) begin
            step();
            chk("w_early", 32'(timeout | done), 0);
        end
        step();
        chk("w_timeout", 32'(timeout), 32'h2);
        chk("w_done",    32'(done), 0);
        step();
        chk("w_pulse",   32'(timeout), 0);
        serve(2, 16'h0200, 1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/pit_arbiter.md
# pit_arbiter

Scheduler that shares the single `minipit` interval timer among `NUM_REQ` requesters. Each requester posts a one-shot timeout (16-bit count plus divider select). The arbiter grants requests round-robin, programs the timer through its write port, waits for the timer interrupt, and returns a one-cycle `done` pulse to the owning requester. It sits between the JTAG/config logic or other clients and the `minipit` instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WDOG_CYCLES`, 20'hFFFFF: watchdog limit in WAIT, in clk cycles. Used only with the watchdog compiled in.

- `clk`  in  1  single clock, all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  request strobe per channel.
- `req_count`  in  NUM_REQ×16  timeout count per channel, `{high,low}`.
- `req_div`  in  NUM_REQ  per-channel divider select.
- `req_ready`  out  NUM_REQ  channel can accept a request (= !pending[i]).
- `done`  out  NUM_REQ  one-cycle completion pulse.
- `timeout`  out  NUM_REQ  one-cycle watchdog-abort pulse.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  $clog2(NUM_REQ)  channel currently being served.
- `pit_write_en`  out  1  to minipit `write_enable`.
- `pit_counter_high`  out  8  to minipit `counter_high`.
- `pit_counter_low`  out  8  to minipit `counter_low`.
- `pit_divider_on`  out  1  to minipit `divider_on`.
- `pit_repeating`  out  1  to minipit `repeating`; constant 1.
- `pit_irq`  in  1  from minipit `interrupting`.

## Operation
- **Accept:** a request is accepted when `req_valid[i] && req_ready[i]`. On accept, the channel latches count and div and sets `pending[i]`. `req_valid` while not ready is dropped silently.
- **FSM states:** IDLE, LOAD, ARM, WAIT, DONE.
  - **IDLE:** if any pending bit is set, pick the first pending channel after `last_grant` (round-robin, wrapping modulo NUM_REQ). Latch it into `grant_id` and set `last_grant` to it.
    - Latched count == 0: go directly to DONE; the timer is not programmed.
    - Otherwise go to LOAD.
  - **LOAD:** `pit_write_en`=1 for exactly one cycle, with high/low/divider driven from the latched values. Next state ARM.
  - **ARM:** one cycle. `pit_irq` is ignored here, which discards any stale interrupt from the previous programming. Next state WAIT.
  - **WAIT:** `pit_irq`=1 moves to DONE.
  - **DONE:** `done[grant_id]`=1 for one cycle and `pending[grant_id]` clears. Next state IDLE.
- `pit_counter_high`/`low`/`divider_on` hold the latched values from LOAD until the next LOAD.
- Accepts on other channels continue in every state.
- A new accept on the granted channel is possible only from the cycle after DONE.

## Timing
- **Reset values:** state IDLE, pending=0, last_grant=NUM_REQ-1 (so channel 0 wins first), all outputs 0 except `req_ready`=all-ones and `pit_repeating`=1.
- **Reset mid-operation:** the FSM aborts immediately and no `done` is issued. The timer keeps its old count, but its interrupt is masked by ARM on the next grant.
- **Latency, accept (cycle 0) to first `pit_write_en`:** cycle 2 (IDLE sees pending at cycle 1, LOAD at cycle 2).
- **Latency, `pit_irq` to `done`:** `pit_irq` sampled high in cycle k gives `done` in cycle k+1.
- **Zero-count request:** `done` appears 2 cycles after accept.
- **Simultaneous requests** in the same cycle: all are latched; service follows round-robin order.
- **Back-to-back:** the minimum gap between two grants is 1 IDLE cycle.

## Configuration
- `PIT_ARBITER_WATCHDOG_EN` defined:
  - A 20-bit cycle counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches `WDOG_CYCLES` without `pit_irq`, the FSM goes to DONE and pulses `timeout[grant_id]` instead of `done`; pending still clears.
  - If `pit_irq` arrives in the same cycle the limit is reached, `done` wins.
- Not defined: WAIT waits indefinitely, the counter is absent, and `timeout` is tied to 0.

## Structure
- **Package `pit_arbiter_pkg`:** FSM state enum, `COUNT_W`=16, `WDOG_W`=20, `NUM_REQ_MAX`=8.
- **Sub-module `rr_arbiter`:** combinational round-robin pick.
  - Inputs: `pending`, `last_grant`.
  - Outputs: `grant_valid`, `grant_idx`.
- All other logic is in `pit_arbiter`.

## Test plan
- **Reset:** reset asserted mid-WAIT → next cycle IDLE, `busy`=0, `req_ready`=4'b1111, no `done`.
- **Single request:** ch2 requests count 16'h0005, div=0 → `pit_write_en` 2 cycles later with high=8'h00, low=8'h05; `pit_irq` at cycle k → `done`=4'b0100 at k+1.
- **Round-robin:** ch0, ch1 and ch3 request in the same cycle → grants in order 0, 1, 3; next round after a new ch0+ch3 request → 0, 3.
- **Zero count and back-pressure:** ch1 count 0 → `done[1]` 2 cycles after accept, no `pit_write_en`; a second ch1 `req_valid` while pending is dropped (`req_ready[1]`=0).
- **Stale IRQ:** `pit_irq` high during ARM → ignored; FSM stays in WAIT until the next `pit_irq`.
- **Watchdog:** with `PIT_ARBITER_WATCHDOG_EN` and `WDOG_CYCLES`=20, no `pit_irq` → `timeout[grant_id]` pulses 20 cycles into WAIT, `done` stays 0, and the next pending channel is granted.
